// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch buffer
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_STEP   = 4;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_mem.sv
// rtl/fetch_buffer_mem.sv - DEPTH-entry register array, one sync write port, one async read port
module fetch_buffer_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  fetch_entry_t       wdata_i,
  input  logic [IDX_W-1:0]   raddr_i,
  output fetch_entry_t       rdata_o
);

  // Contents are don't-care after reset, so the array carries no reset.
  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - IF-to-ID decoupling FIFO; FETCH_BUFFER_BYPASS_EN enables empty-queue bypass
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  input  logic [ADDR_W-1:0]        fetch_pc_i,
  input  logic [DATA_W-1:0]        fetch_instr_i,
  output logic                     fetch_ready_o,
  output logic                     dec_valid_o,
  output logic [ADDR_W-1:0]        dec_pc_o,
  output logic [ADDR_W-1:0]        dec_pcplus4_o,
  output logic [DATA_W-1:0]        dec_instr_o,
  input  logic                     dec_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q, count_d;

  fetch_entry_t wr_entry, rd_entry, head;
  logic         mem_valid, bypass, wr_en, rd_en;

  assign wr_entry      = '{pc: fetch_pc_i, instr: fetch_instr_i};
  assign fetch_ready_o = (count_q != PTR_W'(DEPTH));
  assign mem_valid     = (count_q != '0);
  assign count_o       = count_q;

`ifdef FETCH_BUFFER_BYPASS_EN
  assign bypass = (count_q == '0) & fetch_valid_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign dec_valid_o = mem_valid | bypass;

  // A bypassed entry taken by decode in the same cycle is never stored.
  assign wr_en = fetch_valid_i & fetch_ready_o & ~flush_i & ~(bypass & dec_ready_i);
  assign rd_en = mem_valid & dec_ready_i & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_buffer_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[IDX_W-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q[IDX_W-1:0]),
    .rdata_o (rd_entry)
  );

  always_comb begin
    head = bypass ? wr_entry : rd_entry;
  end

  assign dec_pc_o      = dec_valid_o ? head.pc : '0;
  assign dec_pcplus4_o = dec_valid_o ? head.pc + ADDR_W'(PC_STEP) : '0;
  assign dec_instr_o   = dec_valid_o ? head.instr : DATA_W'(NOP_INSTR);

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - self-checking bench for fetch_buffer; honours FETCH_BUFFER_BYPASS_EN
module tb_fetch_buffer;

`ifdef FETCH_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic [31:0] fetch_pc_i = '0;
  logic [31:0] fetch_instr_i = '0;
  logic        fetch_ready_o;
  logic        dec_valid_o;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_pcplus4_o;
  logic [31:0] dec_instr_o;
  logic        dec_ready_i = 1'b0;
  logic [2:0]  count_o;

  fetch_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_instr_i (fetch_instr_i),
    .fetch_ready_o (fetch_ready_o),
    .dec_valid_o   (dec_valid_o),
    .dec_pc_o      (dec_pc_o),
    .dec_pcplus4_o (dec_pcplus4_o),
    .dec_instr_o   (dec_instr_o),
    .dec_ready_i   (dec_ready_i),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    bit          flush;
    bit          fv;
    logic [31:0] pc;
    bit          dr;
    int          exp_count;
  } vec_t;

  ent_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   popped = 0;

  function automatic logic [31:0] instr_of(logic [31:0] pc);
    return pc ^ 32'hA5C3_0013;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, check the pre-edge view against the scoreboard, advance the model.
  task automatic cycle(bit flush, bit fv, logic [31:0] pc, bit dr);
    int   n;
    bit   byp, exp_valid, exp_ready;
    ent_t h;
    flush_i       = flush;
    fetch_valid_i = fv;
    fetch_pc_i    = pc;
    fetch_instr_i = instr_of(pc);
    dec_ready_i   = dr;
    #2;
    n         = sb.size();
    exp_ready = (n != 4);
    byp       = BYP && (n == 0) && fv && !flush;
    exp_valid = (n != 0) || byp;
    chk("count", 32'(count_o), 32'(n));
    chk("fetch_ready", 32'(fetch_ready_o), 32'(exp_ready));
    chk("dec_valid", 32'(dec_valid_o), 32'(exp_valid));
    if (exp_valid) begin
      h = byp ? '{pc: pc, instr: instr_of(pc)} : sb[0];
      chk("dec_pc", dec_pc_o, h.pc);
      chk("dec_pcplus4", dec_pcplus4_o, h.pc + 32'd4);
      chk("dec_instr", dec_instr_o, h.instr);
    end else begin
      chk("dec_instr_nop", dec_instr_o, 32'h0);
    end
    if (flush) begin
      sb.delete();
    end else if (byp && dr) begin
      popped++;
    end else begin
      if (exp_valid && dr) begin
        void'(sb.pop_front());
        popped++;
      end
      if (fv && exp_ready) sb.push_back('{pc: pc, instr: instr_of(pc)});
    end
    @(posedge clk_i);
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{0, 1, 32'h00, 0, 1};
    vecs[1]  = '{0, 1, 32'h04, 0, 2};
    vecs[2]  = '{0, 1, 32'h08, 0, 3};
    vecs[3]  = '{0, 1, 32'h0C, 0, 4};
    vecs[4]  = '{0, 1, 32'h10, 0, 4};
    vecs[5]  = '{0, 1, 32'h10, 1, 3};
    vecs[6]  = '{0, 1, 32'h10, 0, 4};
    vecs[7]  = '{0, 0, 32'h00, 1, 3};
    vecs[8]  = '{1, 1, 32'h40, 1, 0};
    vecs[9]  = '{0, 0, 32'h00, 0, 0};
    vecs[10] = '{0, 1, 32'hFFFF_FFFC, 0, 1};
    vecs[11] = '{0, 0, 32'h00, 1, 0};

    #12;
    chk("reset_count", 32'(count_o), 32'd0);
    chk("reset_valid", 32'(dec_valid_o), 32'd0);
    chk("reset_ready", 32'(fetch_ready_o), 32'd1);
    chk("reset_pc", dec_pc_o, 32'h0);
    chk("reset_pcplus4", dec_pcplus4_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].flush, vecs[i].fv, vecs[i].pc, vecs[i].dr);
      chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(vecs[i].exp_count));
    end

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'h80 + 32'(4 * i), 0);
    chk("pre_reset_count", 32'(count_o), 32'd3);
    #2;
    rst_i = 1'b0;
    #1;
    chk("midreset_count", 32'(count_o), 32'd0);
    chk("midreset_valid", 32'(dec_valid_o), 32'd0);
    chk("midreset_instr", dec_instr_o, 32'h0);
    chk("midreset_ready", 32'(fetch_ready_o), 32'd1);
    sb.delete();
    fetch_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Streaming through the wrap: ten back-to-back PCs with decode always ready.
    popped = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 32'h100 + 32'(4 * i), 1);
      chk($sformatf("stream%0d_count", i), 32'(count_o), BYP ? 32'd0 : 32'd1);
    end
    cycle(0, 0, 32'h0, 1);
    chk("stream_popped", 32'(popped), 32'd10);
    chk("stream_drained", 32'(count_o), 32'd0);

    // Bypass corner: empty queue, fetch and decode ready together.
    cycle(0, 1, 32'h200, 1);
    chk("byp_count", 32'(count_o), BYP ? 32'd0 : 32'd1);
    chk("byp_next_valid", 32'(dec_valid_o), BYP ? 32'd0 : 32'd1);
    cycle(0, 0, 32'h0, 1);
    chk("byp_drained", 32'(count_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
